// File: rtl/isa_defs.sv
// Shared ISA and fetch-stage definitions.
// Opcodes, instruction field positions and fetch FSM state encodings.
package isa_defs;

    localparam int ADDR_W  = 4;
    localparam int INSTR_W = 25;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOVE = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int OPC_HI  = 24;
    localparam int OPC_LO  = 22;
    localparam int OP1_HI  = 21;
    localparam int OP1_LO  = 19;
    localparam int OP2_HI  = 18;
    localparam int OP2_LO  = 16;
    localparam int DATA_HI = 15;
    localparam int DATA_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program memory: DEPTH x INSTR_W, one write port, one synchronous read port.
// Ports: clk, we/waddr/wdata (write), raddr -> rdata (1-cycle read latency).
module prog_mem #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 25
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [2**ADDR_W];

    // Read-before-write: a same-cycle write to raddr returns the old word.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program memory, PC and fetch FSM.
// Ports: clk, rst, run, prog_we/addr/data, pc_adv in; func, new_func,
//        pc_addr, busy, done, instr_count out.
module instr_fetch
    import isa_defs::*;
#(
    parameter int         ADDR_W  = 4,
    parameter int         INSTR_W = 25,
    parameter logic [2:0] HALT_OP = OP_HALT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               pc_adv,
    output logic [INSTR_W-1:0] func,
    output logic               new_func,
    output logic [ADDR_W-1:0]  pc_addr,
    output logic               busy,
    output logic               done,
    output logic [15:0]        instr_count
);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc_next;
    logic [INSTR_W-1:0] rdata;
    logic               mem_we;
    logic               rd_halt;
    logic               fn_halt;

    assign mem_we  = prog_we &&
                     (state == S_IDLE || state == S_DONE);
    assign rd_halt = rdata[INSTR_W-1 -: 3] == HALT_OP;
    assign fn_halt = func[INSTR_W-1 -: 3] == HALT_OP;

    // Memory is addressed with the next PC so the word is
    // already registered by the end of FETCH.
    always_comb begin
        pc_next = pc_addr;
        case (state)
            S_IDLE, S_DONE:
                if (run)
                    pc_next = '0;
            S_WAIT:
                if (pc_adv)
                    pc_next = pc_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            default: pc_next = pc_addr;
        endcase
    end

    prog_mem #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_next),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc_addr     <= '0;
            func        <= '0;
            new_func    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            instr_count <= '0;
        end else begin
            new_func <= 1'b0;
            pc_addr  <= pc_next;
            case (state)
                S_IDLE, S_DONE: begin
                    if (run) begin
                        state       <= S_FETCH;
                        instr_count <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state    <= S_ISSUE;
                    func     <= rdata;
                    new_func <= !rd_halt;
                end
                S_ISSUE: begin
                    if (fn_halt) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pc_adv) begin
                        state <= S_FETCH;
                        if (instr_count != 16'hFFFF)
                            instr_count <= instr_count + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a program-walk reference model.
// Model: array copy of program memory, expected PC and retired count.
module tb_instr_fetch;

    localparam int AW = 4;
    localparam int IW = 25;
    localparam int DEPTH = 16;
    localparam logic [IW-1:0] HALT_W = 25'h1C00000;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic          pc_adv;
    logic [IW-1:0] func;
    logic          new_func;
    logic [AW-1:0] pc_addr;
    logic          busy;
    logic          done;
    logic [15:0]   instr_count;

    int checks = 0;
    int failures = 0;

    logic [IW-1:0] mm [DEPTH];
    int            exp_pc;
    int            exp_cnt;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .pc_adv      (pc_adv),
        .func        (func),
        .new_func    (new_func),
        .pc_addr     (pc_addr),
        .busy        (busy),
        .done        (done),
        .instr_count (instr_count)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic wr(input int a, input logic [IW-1:0] d);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
        mm[a] = d;
    endtask

    function automatic logic [IW-1:0] rnd_op();
        logic [2:0] op;
        op = 3'($urandom_range(0, 3));
        return {op, 3'($urandom), 3'($urandom), 16'($urandom)};
    endfunction

    // Walk the program from the model. Returns at the ISSUE sample
    // after n_adv advances, or one cycle after HALT is reached.
    // start=0 resumes from a WAIT left by an earlier call.
    task automatic exec(input bit start, input int n_adv,
                        input int dly);
        int adv;
        bit skip;
        logic [IW-1:0] w;
        adv  = 0;
        skip = !start;
        if (start) begin
            run = 1'b1;
            @(negedge clk);
            run = 1'b0;
            exp_pc  = 0;
            exp_cnt = 0;
        end
        for (int it = 0; it < 64; it++) begin
            if (!skip) begin
                w = mm[exp_pc];
                chk("fetch_nf", 32'(new_func), 0);
                chk("fetch_busy", 32'(busy), 1);
                chk("fetch_pc", 32'(pc_addr), 32'(exp_pc));
                pc_adv = 1'($urandom);
                @(negedge clk);
                pc_adv = 1'($urandom);
                chk("issue_func", 32'(func), 32'(w));
                chk("issue_cnt", 32'(instr_count), 32'(exp_cnt));
                if (w[24:22] == 3'b111) begin
                    chk("halt_nf", 32'(new_func), 0);
                    @(negedge clk);
                    pc_adv = 1'b0;
                    chk("done", 32'(done), 1);
                    chk("done_busy", 32'(busy), 0);
                    chk("done_pc", 32'(pc_addr), 32'(exp_pc));
                    chk("done_cnt", 32'(instr_count), 32'(exp_cnt));
                    chk("done_func", 32'(func), 32'(w));
                    return;
                end
                chk("issue_nf", 32'(new_func), 1);
                chk("issue_pc", 32'(pc_addr), 32'(exp_pc));
                if (adv == n_adv) begin
                    pc_adv = 1'b0;
                    return;
                end
            end
            skip = 1'b0;
            begin
                int d;
                d = (dly == 0) ? $urandom_range(1, 4) : dly;
                for (int k = 0; k < d; k++) begin
                    @(negedge clk);
                    pc_adv = 1'b0;
                    chk("wait_nf", 32'(new_func), 0);
                    chk("wait_func", 32'(func), 32'(mm[exp_pc]));
                    chk("wait_busy", 32'(busy), 1);
                end
            end
            pc_adv = 1'b1;
            @(negedge clk);
            pc_adv = 1'b0;
            exp_pc  = (exp_pc + 1) % DEPTH;
            exp_cnt = exp_cnt + 1;
            adv++;
        end
        chk("exec_bound", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        pc_adv = 1'b0;
        exp_pc = 0;
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_func", 32'(func), 0);
        chk("rst_nf", 32'(new_func), 0);
        chk("rst_pc", 32'(pc_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", 32'(instr_count), 0);

        // pc_adv in IDLE is ignored
        pc_adv = 1'b1;
        repeat (2) @(negedge clk);
        pc_adv = 1'b0;
        @(negedge clk);
        chk("idle_adv_pc", 32'(pc_addr), 0);
        chk("idle_adv_busy", 32'(busy), 0);
        chk("idle_adv_cnt", 32'(instr_count), 0);

        // Small program, fixed 2-cycle then 20-cycle pc_adv spacing
        wr(0, 25'h000005);
        wr(1, 25'h0A0000);
        wr(2, HALT_W);
        exec(1'b1, 40, 2);
        chk("t1_cnt", 32'(instr_count), 2);
        chk("t1_pc", 32'(pc_addr), 2);
        exec(1'b1, 40, 20);

        // No HALT: wrap after 16 advances
        for (int a = 0; a < DEPTH; a++)
            wr(a, {3'b001, 3'($urandom), 3'($urandom), 16'($urandom)});
        exec(1'b1, 17, 0);
        chk("wrap_cnt", 32'(instr_count), 17);
        chk("wrap_pc", 32'(pc_addr), 1);

        // Async reset at ISSUE while new_func is high
        rst = 1'b1;
        #1;
        chk("arst_nf", 32'(new_func), 0);
        chk("arst_func", 32'(func), 0);
        chk("arst_pc", 32'(pc_addr), 0);
        chk("arst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Writes and run while busy are dropped
        wr(0, rnd_op());
        wr(1, rnd_op());
        wr(2, rnd_op());
        wr(3, {3'b001, 3'd2, 3'd5, 16'hBEEF});
        wr(4, HALT_W);
        exec(1'b1, 1, 0);
        prog_we = 1'b1;
        prog_addr = 4'd3;
        prog_data = 25'h1234567;
        run = 1'b1;
        @(negedge clk);
        prog_we = 1'b0;
        run = 1'b0;
        @(negedge clk);
        chk("busy_run_pc", 32'(pc_addr), 1);
        chk("busy_run_nf", 32'(new_func), 0);
        chk("busy_run_busy", 32'(busy), 1);
        exec(1'b0, 40, 0);

        // Randomized programs, restarted from DONE each time
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 15);
            for (int a = 0; a < DEPTH; a++)
                wr(a, (a == len) ? HALT_W : rnd_op());
            exec(1'b1, 40, 0);
            chk("rnd_cnt", 32'(instr_count), 32'(len));
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
